// File: rtl/cpu_phase_ctrl.sv
// Phase sequencer for the non-pipelined CPU: one-hot fetch/exec strobes, run/step
// control, halt on STP, optional RAM wait states and saturating performance counters.
module cpu_phase_ctrl #(
  parameter int         WAIT_STATES = 0,
  parameter int         CNT_W       = 16,
  parameter logic [4:0] STP_OP      = 5'b11110
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             step,
  input  logic [4:0]       opcode,
  input  logic             extra,
  input  logic             extra2,
  output logic             fetch,
  output logic             exec1,
  output logic             exec2,
  output logic             exec3,
  output logic             commit,
  output logic             ir_load,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int WW = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_STATES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC1,
    S_EXEC2,
    S_EXEC3,
    S_HALT
  } state_t;

  state_t        state, state_n;
  logic          ss, ss_n;
  logic [WW-1:0] wcnt;
  logic          done;

  // All strobes decode straight from registers, so they are glitch-free and one-hot.
  always_comb begin
    fetch   = (state == S_FETCH);
    exec1   = (state == S_EXEC1);
    exec2   = (state == S_EXEC2);
    exec3   = (state == S_EXEC3);
    halted  = (state == S_HALT);
    busy    = fetch | exec1 | exec2 | exec3;
    commit  = busy && (wcnt == WAIT_LAST);
    ir_load = fetch && commit;
  end

  always_comb begin
    state_n = state;
    ss_n    = ss;
    done    = 1'b0;
    case (state)
      S_IDLE: begin
        if (run) begin
          state_n = S_FETCH;
          ss_n    = 1'b0;
        end else if (step) begin
          state_n = S_FETCH;
          ss_n    = 1'b1;
        end
      end
      S_FETCH: if (commit) state_n = S_EXEC1;
      S_EXEC1: begin
        if (commit) begin
          if (opcode == STP_OP) state_n = S_HALT;
          else if (extra)       state_n = S_EXEC2;
          else                  done    = 1'b1;
        end
      end
      S_EXEC2: begin
        if (commit) begin
          if (extra2) state_n = S_EXEC3;
          else        done    = 1'b1;
        end
      end
      S_EXEC3: if (commit) done = 1'b1;
      S_HALT:  state_n = S_HALT;
      default: state_n = S_IDLE;
    endcase
    // run is only consulted at an instruction boundary, so dropping it never aborts one.
    if (done) state_n = (ss || !run) ? S_IDLE : S_FETCH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ss        <= 1'b0;
      wcnt      <= '0;
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      state <= state_n;
      ss    <= ss_n;
      wcnt  <= (busy && !commit) ? wcnt + WW'(1) : '0;
      if (busy && (cycle_cnt != '1)) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (done && (instr_cnt != '1)) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_phase_ctrl.sv
// Bench for cpu_phase_ctrl: three instances (no wait states, two wait states,
// 4-bit counters) share stimulus; each scenario checks the instance it targets.
module tb_cpu_phase_ctrl;

  localparam logic [4:0] OP_LDI = 5'b00001;
  localparam logic [4:0] OP_STP = 5'b11110;

  // {fetch, exec1, exec2, exec3, commit, ir_load, busy, halted}
  localparam logic [7:0] V_IDLE = 8'b0000_0000;
  localparam logic [7:0] V_F    = 8'b1000_1110;
  localparam logic [7:0] V_E1   = 8'b0100_1010;
  localparam logic [7:0] V_E2   = 8'b0010_1010;
  localparam logic [7:0] V_E3   = 8'b0001_1010;
  localparam logic [7:0] V_HALT = 8'b0000_0001;
  localparam logic [7:0] V_FW   = 8'b1000_0010;
  localparam logic [7:0] V_E1W  = 8'b0100_0010;

  logic       clk, rst_n, run, step, extra, extra2;
  logic [4:0] opcode;

  logic        a_fetch, a_exec1, a_exec2, a_exec3, a_commit, a_ir_load, a_busy, a_halted;
  logic [15:0] a_cycle, a_instr;
  logic        b_fetch, b_exec1, b_exec2, b_exec3, b_commit, b_ir_load, b_busy, b_halted;
  logic [15:0] b_cycle, b_instr;
  logic        c_fetch, c_exec1, c_exec2, c_exec3, c_commit, c_ir_load, c_busy, c_halted;
  logic [3:0]  c_cycle, c_instr;

  wire [7:0] vec_a = {a_fetch, a_exec1, a_exec2, a_exec3, a_commit, a_ir_load, a_busy, a_halted};
  wire [7:0] vec_b = {b_fetch, b_exec1, b_exec2, b_exec3, b_commit, b_ir_load, b_busy, b_halted};
  wire [7:0] vec_c = {c_fetch, c_exec1, c_exec2, c_exec3, c_commit, c_ir_load, c_busy, c_halted};

  logic [7:0] exp_q[$];
  int n_vec  = 0;
  int n_fail = 0;

  cpu_phase_ctrl #(.WAIT_STATES(0), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .opcode(opcode),
    .extra(extra), .extra2(extra2), .fetch(a_fetch), .exec1(a_exec1),
    .exec2(a_exec2), .exec3(a_exec3), .commit(a_commit), .ir_load(a_ir_load),
    .busy(a_busy), .halted(a_halted), .cycle_cnt(a_cycle), .instr_cnt(a_instr)
  );

  cpu_phase_ctrl #(.WAIT_STATES(2), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .opcode(opcode),
    .extra(extra), .extra2(extra2), .fetch(b_fetch), .exec1(b_exec1),
    .exec2(b_exec2), .exec3(b_exec3), .commit(b_commit), .ir_load(b_ir_load),
    .busy(b_busy), .halted(b_halted), .cycle_cnt(b_cycle), .instr_cnt(b_instr)
  );

  cpu_phase_ctrl #(.WAIT_STATES(0), .CNT_W(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .opcode(opcode),
    .extra(extra), .extra2(extra2), .fetch(c_fetch), .exec1(c_exec1),
    .exec2(c_exec2), .exec3(c_exec3), .commit(c_commit), .ir_load(c_ir_load),
    .busy(c_busy), .halted(c_halted), .cycle_cnt(c_cycle), .instr_cnt(c_instr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; run = 1'b0; step = 1'b0; extra = 1'b0; extra2 = 1'b0; opcode = OP_LDI;
    #2;
    rst_n = 1'b1;
  endtask

  // Drive inputs for the coming edge, push the phase vector expected after it,
  // then pop and compare once the DUT has moved.
  task automatic cyc(input int sel, input logic r, input logic s, input logic ex,
                     input logic ex2, input logic [7:0] exp, input string name);
    logic [7:0] got, want;
    run = r; step = s; extra = ex; extra2 = ex2;
    exp_q.push_back(exp);
    @(negedge clk);
    got  = (sel == 0) ? vec_a : (sel == 1) ? vec_b : vec_c;
    want = exp_q.pop_front();
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; step = 1'b0; extra = 1'b0; extra2 = 1'b0; opcode = OP_LDI;
    #12;
    n_vec++;
    if ({vec_a, vec_b, vec_c} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 000000", {vec_a, vec_b, vec_c});
    end
    n_vec++;
    if ({a_cycle, a_instr, b_cycle, b_instr, c_cycle, c_instr} !== 72'h0) begin
      n_fail++;
      $display("FAIL reset_counters: got %h/%h %h/%h %h/%h required all 0",
               a_cycle, a_instr, b_cycle, b_instr, c_cycle, c_instr);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_ldi_run();
    do_reset();
    cyc(0, 1, 0, 0, 0, V_F,  "ldi_fetch");
    cyc(0, 1, 0, 0, 0, V_E1, "ldi_exec1");
    cyc(0, 1, 0, 0, 0, V_F,  "ldi_loop");
    n_vec++;
    if (a_instr !== 16'd1 || a_cycle !== 16'd2) begin
      n_fail++;
      $display("FAIL ldi_counts: got instr %0d cycle %0d required 1 2", a_instr, a_cycle);
    end
    cyc(0, 0, 0, 0, 0, V_E1,   "ldi2_exec1");
    cyc(0, 0, 0, 0, 0, V_IDLE, "ldi2_idle");
    n_vec++;
    if (a_instr !== 16'd2 || a_cycle !== 16'd4) begin
      n_fail++;
      $display("FAIL ldi_stop_counts: got instr %0d cycle %0d required 2 4", a_instr, a_cycle);
    end
  endtask

  task automatic test_ldn_sta();
    do_reset();
    cyc(0, 1, 0, 1, 1, V_F,  "ldn_fetch");
    cyc(0, 1, 0, 1, 1, V_E1, "ldn_exec1");
    cyc(0, 1, 0, 1, 1, V_E2, "ldn_exec2");
    cyc(0, 1, 0, 1, 1, V_E3, "ldn_exec3");
    cyc(0, 1, 0, 0, 0, V_F,  "sta_fetch");
    cyc(0, 1, 0, 0, 0, V_E1, "sta_exec1");
    n_vec++;
    if (a_instr !== 16'd1) begin
      n_fail++;
      $display("FAIL ldn_mid_count: got %0d required 1", a_instr);
    end
    cyc(0, 0, 0, 0, 0, V_IDLE, "sta_idle");
    n_vec++;
    if (a_instr !== 16'd2 || a_cycle !== 16'd6) begin
      n_fail++;
      $display("FAIL ldn_sta_counts: got instr %0d cycle %0d required 2 6", a_instr, a_cycle);
    end
  endtask

  task automatic test_single_step();
    do_reset();
    cyc(0, 0, 1, 1, 0, V_F,    "step_fetch");
    cyc(0, 0, 0, 1, 0, V_E1,   "step_exec1");
    cyc(0, 0, 1, 1, 0, V_E2,   "step_ignored_exec2");
    cyc(0, 0, 0, 1, 0, V_IDLE, "step_idle");
    cyc(0, 0, 0, 0, 0, V_IDLE, "step_stay_idle");
    n_vec++;
    if (a_instr !== 16'd1 || a_cycle !== 16'd3) begin
      n_fail++;
      $display("FAIL step_counts: got instr %0d cycle %0d required 1 3", a_instr, a_cycle);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cyc(0, 0, 1, 0, 0, V_F,    "held_step_f1");
    cyc(0, 0, 1, 0, 0, V_E1,   "held_step_e1");
    cyc(0, 0, 1, 0, 0, V_IDLE, "held_step_idle");
    cyc(0, 0, 1, 0, 0, V_F,    "held_step_f2");
    cyc(0, 0, 0, 0, 0, V_E1,   "held_step_e2");
    cyc(0, 0, 0, 0, 0, V_IDLE, "held_step_idle2");
    cyc(0, 1, 1, 0, 0, V_F,    "run_step_f");
    cyc(0, 1, 1, 0, 0, V_E1,   "run_step_e1");
    cyc(0, 1, 1, 0, 0, V_F,    "run_wins_loop");
    cyc(0, 0, 0, 0, 0, V_E1,   "run_step_e1b");
    cyc(0, 0, 0, 0, 0, V_IDLE, "run_step_idle");
    n_vec++;
    if (a_instr !== 16'd4) begin
      n_fail++;
      $display("FAIL back_to_back_count: got %0d required 4", a_instr);
    end
  endtask

  task automatic test_wait_states();
    do_reset();
    cyc(1, 1, 0, 0, 0, V_FW,   "ws_fetch0");
    cyc(1, 1, 0, 0, 0, V_FW,   "ws_fetch1");
    cyc(1, 1, 0, 0, 0, V_F,    "ws_fetch_commit");
    cyc(1, 1, 0, 0, 0, V_E1W,  "ws_exec0");
    cyc(1, 1, 0, 0, 0, V_E1W,  "ws_exec1");
    cyc(1, 1, 0, 0, 0, V_E1,   "ws_exec_commit");
    cyc(1, 0, 0, 0, 0, V_IDLE, "ws_idle");
    n_vec++;
    if (b_instr !== 16'd1 || b_cycle !== 16'd6) begin
      n_fail++;
      $display("FAIL ws_counts: got instr %0d cycle %0d required 1 6", b_instr, b_cycle);
    end
  endtask

  task automatic test_halt();
    do_reset();
    cyc(0, 1, 0, 0, 0, V_F,  "stp_fetch");
    cyc(0, 1, 0, 0, 0, V_E1, "stp_exec1");
    opcode = OP_STP;
    cyc(0, 1, 0, 1, 1, V_HALT, "stp_enter_halt");
    opcode = OP_LDI;
    for (int i = 0; i < 12; i++)
      cyc(0, 1, $urandom_range(0, 1), 0, 0, V_HALT, "halt_hold");
    n_vec++;
    if (a_instr !== 16'd0) begin
      n_fail++;
      $display("FAIL halt_instr: got %0d required 0", a_instr);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (vec_a !== V_IDLE) begin
      n_fail++;
      $display("FAIL halt_reset: got %b required %b", vec_a, V_IDLE);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_run_drop_and_reset();
    do_reset();
    cyc(0, 1, 0, 1, 1, V_F,    "adn_fetch");
    cyc(0, 1, 0, 1, 1, V_E1,   "adn_exec1");
    cyc(0, 1, 0, 1, 1, V_E2,   "adn_exec2");
    cyc(0, 0, 0, 1, 1, V_E3,   "adn_exec3_after_drop");
    cyc(0, 0, 0, 1, 1, V_IDLE, "adn_idle");
    n_vec++;
    if (a_instr !== 16'd1) begin
      n_fail++;
      $display("FAIL run_drop_count: got %0d required 1", a_instr);
    end
    do_reset();
    cyc(0, 1, 0, 1, 1, V_F,  "mid_fetch");
    cyc(0, 1, 0, 1, 1, V_E1, "mid_exec1");
    cyc(0, 1, 0, 1, 1, V_E2, "mid_exec2");
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (vec_a !== V_IDLE || a_cycle !== 16'd0 || a_instr !== 16'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %b cycle %0d instr %0d required %b 0 0",
               vec_a, a_cycle, a_instr, V_IDLE);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_saturation();
    do_reset();
    run = 1'b1;
    repeat (29) @(negedge clk);
    n_vec++;
    if (c_instr !== 4'd14 || c_cycle !== 4'd15) begin
      n_fail++;
      $display("FAIL sat_pre: got instr %0d cycle %0d required 14 15", c_instr, c_cycle);
    end
    repeat (2) @(negedge clk);
    n_vec++;
    if (c_instr !== 4'd15) begin
      n_fail++;
      $display("FAIL sat_reach: got %0d required 15", c_instr);
    end
    repeat (10) @(negedge clk);
    run = 1'b0;
    repeat (4) @(negedge clk);
    n_vec++;
    if (c_instr !== 4'd15 || c_cycle !== 4'd15) begin
      n_fail++;
      $display("FAIL sat_hold: got instr %0d cycle %0d required 15 15", c_instr, c_cycle);
    end
  endtask

  initial begin
    test_reset();
    test_ldi_run();
    test_ldn_sta();
    test_single_step();
    test_back_to_back();
    test_wait_states();
    test_halt();
    test_run_drop_and_reset();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
